gerenciador_inimigos: RTL and testbench

//   Parametrised enemy-ball manager for the shooter: N independent enemy balls, each bouncing horizontally.

---
 rtl/jogo_pkg.sv | 13 +
 rtl/inimigo.sv | 141 ++++++++++++++
 rtl/gerenciador_inimigos.sv | 114 +++++++++++
 tb/tb_gerenciador_inimigos.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// rtl/jogo_pkg.sv - shared screen geometry, coordinate width and enemy state type
package jogo_pkg;

  localparam int LARGURA_TELA = 640;
  localparam int ALTURA_TELA  = 480;
  localparam int LARG_COORD   = 10;

  typedef enum logic {
    INATIVO = 1'b0,
    ATIVO   = 1'b1
  } estado_t;

endpackage

// File: rtl/inimigo.sv
// rtl/inimigo.sv - one enemy ball: FSM, horizontal bounce, ball/ship compares
// INIMIGO_RESPAWN_EN adds the respawn countdown in INATIVO.
module inimigo
  import jogo_pkg::*;
#(
  parameter int X_INI = 80,
  parameter int Y_INI = 100,
  parameter int RAIO  = 5,
  parameter int VEL   = 2
`ifdef INIMIGO_RESPAWN_EN
  ,
  parameter int RESPAWN_TICKS = 200
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pausa,
  input  logic                  tick,
  input  logic                  destruir,
  input  logic [LARG_COORD-1:0] x_bola,
  input  logic [LARG_COORD-1:0] y_bola,
  input  logic [LARG_COORD-1:0] raio_bola,
  input  logic [LARG_COORD-1:0] x_nave,
  input  logic [LARG_COORD-1:0] y_nave,
  input  logic [LARG_COORD-1:0] largura_nave,
  input  logic [LARG_COORD-1:0] altura_nave,
  output logic [LARG_COORD-1:0] x,
  output logic [LARG_COORD-1:0] y,
  output logic                  ativo,
  output logic                  pedido_acerto,
  output logic                  contato
);

  localparam logic signed [10:0] R11 = 11'(RAIO);
  localparam logic signed [10:0] V11 = 11'(VEL);
  localparam logic signed [10:0] LIM = 11'(LARGURA_TELA - 1);
  localparam logic signed [11:0] R12 = 12'(RAIO);

  estado_t                 estado_q, estado_d;
  logic [LARG_COORD-1:0]   x_q, x_d;
  logic                    dir_q, dir_d;
  logic signed [10:0]      nx;
  logic signed [11:0]      xe, ye, xb, yb, xn, yn, ln, an;
  logic signed [11:0]      dx, dy, adx, ady, soma;
  logic                    bate_bola, bate_nave;

`ifdef INIMIGO_RESPAWN_EN
  logic [15:0] timer_q, timer_d;
`endif

  assign x     = x_q;
  assign y     = 10'(Y_INI);
  assign ativo = (estado_q == ATIVO);

  // 12-bit signed so ship right/bottom edges (up to 2046) never wrap
  assign xe   = $signed({2'b00, x_q});
  assign ye   = $signed(12'(Y_INI));
  assign xb   = $signed({2'b00, x_bola});
  assign yb   = $signed({2'b00, y_bola});
  assign xn   = $signed({2'b00, x_nave});
  assign yn   = $signed({2'b00, y_nave});
  assign ln   = $signed({2'b00, largura_nave});
  assign an   = $signed({2'b00, altura_nave});
  assign soma = R12 + $signed({2'b00, raio_bola});
  assign dx   = xe - xb;
  assign dy   = ye - yb;
  assign adx  = dx[11] ? -dx : dx;
  assign ady  = dy[11] ? -dy : dy;

  assign bate_bola = (adx < soma) && (ady < soma);
  assign bate_nave = (xe - R12 <= xn + ln) && (xe + R12 >= xn) &&
                     (ye - R12 <= yn + an) && (ye + R12 >= yn);

  assign pedido_acerto = ativo && !pausa && bate_bola;
  assign contato       = ativo && !pausa && bate_nave;

  assign nx = $signed({1'b0, x_q}) + (dir_q ? V11 : -V11);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= ATIVO;
      x_q      <= 10'(X_INI);
      dir_q    <= 1'b1;
`ifdef INIMIGO_RESPAWN_EN
      timer_q  <= 16'd0;
`endif
    end else begin
      estado_q <= estado_d;
      x_q      <= x_d;
      dir_q    <= dir_d;
`ifdef INIMIGO_RESPAWN_EN
      timer_q  <= timer_d;
`endif
    end
  end

  always_comb begin
    estado_d = estado_q;
    x_d      = x_q;
    dir_d    = dir_q;
`ifdef INIMIGO_RESPAWN_EN
    timer_d  = timer_q;
`endif
    case (estado_q)
      ATIVO: begin
        if (destruir) begin
          estado_d = INATIVO;
`ifdef INIMIGO_RESPAWN_EN
          timer_d  = 16'(RESPAWN_TICKS);
`endif
        end else if (tick) begin
          if (nx - R11 <= 11'sd0) begin
            x_d   = 10'(RAIO);
            dir_d = 1'b1;
          end else if (nx + R11 >= LIM) begin
            x_d   = 10'(LARGURA_TELA - 1 - RAIO);
            dir_d = 1'b0;
          end else begin
            x_d = nx[9:0];
          end
        end
      end
      INATIVO: begin
`ifdef INIMIGO_RESPAWN_EN
        if (tick) begin
          if (timer_q <= 16'd1) begin
            estado_d = ATIVO;
            x_d      = 10'(X_INI);
            dir_d    = 1'b1;
            timer_d  = 16'd0;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
`endif
      end
      default: estado_d = ATIVO;
    endcase
  end

endmodule

// File: rtl/gerenciador_inimigos.sv
// rtl/gerenciador_inimigos.sv - N bouncing enemies, tick divider, hit priority, score
// INIMIGO_RESPAWN_EN enables respawn of destroyed enemies after RESPAWN_TICKS ticks.
module gerenciador_inimigos
  import jogo_pkg::*;
#(
  parameter int N_INIMIGOS   = 4,
  parameter int RAIO_INIMIGO = 5,
  parameter int X0           = 80,
  parameter int Y0           = 100,
  parameter int ESPACO       = 120,
  parameter int VEL          = 2,
  parameter int TICK_DIV     = 500000
`ifdef INIMIGO_RESPAWN_EN
  ,
  parameter int RESPAWN_TICKS = 200
`endif
) (
  input  logic                             CLOCK_50,
  input  logic                             reset,
  input  logic                             pausa,
  input  logic                             reiniciarJogo,
  input  logic [LARG_COORD-1:0]            x_bola,
  input  logic [LARG_COORD-1:0]            y_bola,
  input  logic [LARG_COORD-1:0]            raio_bola,
  input  logic [LARG_COORD-1:0]            x_nave,
  input  logic [LARG_COORD-1:0]            y_nave,
  input  logic [LARG_COORD-1:0]            largura_nave,
  input  logic [LARG_COORD-1:0]            altura_nave,
  output logic [LARG_COORD*N_INIMIGOS-1:0] x_inimigos,
  output logic [LARG_COORD*N_INIMIGOS-1:0] y_inimigos,
  output logic [LARG_COORD*N_INIMIGOS-1:0] raio_inimigos,
  output logic [N_INIMIGOS-1:0]            ativos,
  output logic                             acerto,
  output logic [15:0]                      pontos,
  output logic                             nave_atingida,
  output logic                             fim_onda
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic                  rst;
  logic [CW-1:0]         cnt;
  logic                  tick;
  logic [N_INIMIGOS-1:0] pedido, grant, contato;

  assign rst  = reset | reiniciarJogo;
  assign tick = !pausa && (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge CLOCK_50) begin
    if (rst)
      cnt <= '0;
    else if (!pausa)
      cnt <= tick ? '0 : cnt + CW'(1);
  end

  // isolate the lowest requesting enemy; the others keep requesting next cycle
  assign grant = pedido & (~pedido + N_INIMIGOS'(1));

  genvar i;
  generate
    for (i = 0; i < N_INIMIGOS; i++) begin : g_inimigo
      logic [LARG_COORD-1:0] xi, yi;
      inimigo #(
        .X_INI (X0 + i * ESPACO),
        .Y_INI (Y0),
        .RAIO  (RAIO_INIMIGO),
        .VEL   (VEL)
`ifdef INIMIGO_RESPAWN_EN
        ,
        .RESPAWN_TICKS (RESPAWN_TICKS)
`endif
      ) u_inimigo (
        .clk           (CLOCK_50),
        .rst           (rst),
        .pausa         (pausa),
        .tick          (tick),
        .destruir      (grant[i]),
        .x_bola        (x_bola),
        .y_bola        (y_bola),
        .raio_bola     (raio_bola),
        .x_nave        (x_nave),
        .y_nave        (y_nave),
        .largura_nave  (largura_nave),
        .altura_nave   (altura_nave),
        .x             (xi),
        .y             (yi),
        .ativo         (ativos[i]),
        .pedido_acerto (pedido[i]),
        .contato       (contato[i])
      );
      assign x_inimigos[LARG_COORD*i +: LARG_COORD]    = xi;
      assign y_inimigos[LARG_COORD*i +: LARG_COORD]    = yi;
      assign raio_inimigos[LARG_COORD*i +: LARG_COORD] =
        ativos[i] ? LARG_COORD'(RAIO_INIMIGO) : '0;
    end
  endgenerate

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      acerto        <= 1'b0;
      pontos        <= 16'd0;
      nave_atingida <= 1'b0;
    end else begin
      acerto <= |pedido;
      if (|pedido && pontos != 16'hFFFF)
        pontos <= pontos + 16'd1;
      if (|contato)
        nave_atingida <= 1'b1;
    end
  end

  assign fim_onda = (ativos == '0);

endmodule

// File: tb/tb_gerenciador_inimigos.sv
// tb/tb_gerenciador_inimigos.sv - scoreboard bench for gerenciador_inimigos (N=4, TICK_DIV=4)
module tb_gerenciador_inimigos;

  logic        clk = 1'b0;
  logic        reset, pausa, reiniciarJogo;
  logic [9:0]  x_bola, y_bola, raio_bola;
  logic [9:0]  x_nave, y_nave, largura_nave, altura_nave;
  logic [39:0] x_inimigos, y_inimigos, raio_inimigos;
  logic [3:0]  ativos;
  logic        acerto, nave_atingida, fim_onda;
  logic [15:0] pontos;

  typedef struct {
    logic [3:0]  ativos;
    logic [15:0] pontos;
  } exp_t;

  exp_t fila[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  gerenciador_inimigos #(
    .N_INIMIGOS (4),
    .TICK_DIV   (4)
`ifdef INIMIGO_RESPAWN_EN
    ,
    .RESPAWN_TICKS (3)
`endif
  ) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .pausa         (pausa),
    .reiniciarJogo (reiniciarJogo),
    .x_bola        (x_bola),
    .y_bola        (y_bola),
    .raio_bola     (raio_bola),
    .x_nave        (x_nave),
    .y_nave        (y_nave),
    .largura_nave  (largura_nave),
    .altura_nave   (altura_nave),
    .x_inimigos    (x_inimigos),
    .y_inimigos    (y_inimigos),
    .raio_inimigos (raio_inimigos),
    .ativos        (ativos),
    .acerto        (acerto),
    .pontos        (pontos),
    .nave_atingida (nave_atingida),
    .fim_onda      (fim_onda)
  );

  task automatic bola_longe();
    x_bola = 10'd0; y_bola = 10'd400; raio_bola = 10'd0;
  endtask

  task automatic nave_longe();
    x_nave = 10'd0; y_nave = 10'd400; largura_nave = 10'd10; altura_nave = 10'd10;
  endtask

  // reset held over two edges; returns on the negedge where reset is released
  task automatic aplicar_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic esperar_acerto(input string nome, input int limite);
    exp_t e;
    int   visto = 0;
    for (int k = 0; k < limite; k++) begin
      @(negedge clk);
      if (acerto) begin
        visto = 1;
        break;
      end
    end
    n_cmp++;
    if (!visto) begin
      n_err++;
      $display("FAIL %s: acerto not seen, required within %0d cycles", nome, limite);
      if (fila.size() > 0) void'(fila.pop_front());
    end else if (fila.size() == 0) begin
      n_err++;
      $display("FAIL %s: acerto seen, required none (scoreboard empty)", nome);
    end else begin
      e = fila.pop_front();
      n_cmp++;
      if (ativos !== e.ativos) begin
        n_err++;
        $display("FAIL %s ativos: got %b required %b", nome, ativos, e.ativos);
      end
      if (pontos !== e.pontos) begin
        n_err++;
        $display("FAIL %s pontos: got %0d required %0d", nome, pontos, e.pontos);
      end
    end
  endtask

  task automatic test_reset();
    pausa = 1'b0; reiniciarJogo = 1'b0;
    bola_longe(); nave_longe();
    aplicar_reset();
    n_cmp++;
    if (x_inimigos !== {10'd440, 10'd320, 10'd200, 10'd80}) begin
      n_err++; $display("FAIL reset_x: got %h required %h", x_inimigos, {10'd440, 10'd320, 10'd200, 10'd80});
    end
    n_cmp++;
    if (y_inimigos !== {4{10'd100}}) begin
      n_err++; $display("FAIL reset_y: got %h required %h", y_inimigos, {4{10'd100}});
    end
    n_cmp++;
    if (raio_inimigos !== {4{10'd5}}) begin
      n_err++; $display("FAIL reset_raio: got %h required %h", raio_inimigos, {4{10'd5}});
    end
    n_cmp++;
    if ({ativos, acerto, nave_atingida, fim_onda} !== 7'b1111_000 || pontos !== 16'd0) begin
      n_err++; $display("FAIL reset_flags: ativos=%b acerto=%b nave=%b fim=%b pontos=%0d required 1111 0 0 0 0",
                        ativos, acerto, nave_atingida, fim_onda, pontos);
    end
  endtask

  task automatic test_motion();
    int houve_acerto = 0;
    aplicar_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (acerto) houve_acerto = 1;
    end
    n_cmp++;
    if (x_inimigos[9:0] !== 10'd100 || x_inimigos[39:30] !== 10'd460) begin
      n_err++; $display("FAIL motion_10: x0=%0d x3=%0d required 100 460", x_inimigos[9:0], x_inimigos[39:30]);
    end
    repeat (4 * 87) @(negedge clk);
    n_cmp++;
    if (x_inimigos[39:30] !== 10'd634) begin
      n_err++; $display("FAIL bounce_clamp: x3=%0d required 634", x_inimigos[39:30]);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (x_inimigos[39:30] !== 10'd632) begin
      n_err++; $display("FAIL bounce_back1: x3=%0d required 632", x_inimigos[39:30]);
    end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (x_inimigos[39:30] !== 10'd628 || houve_acerto != 0 || pontos !== 16'd0) begin
      n_err++; $display("FAIL bounce_back3: x3=%0d acerto_seen=%0d pontos=%0d required 628 0 0",
                        x_inimigos[39:30], houve_acerto, pontos);
    end
  endtask

  task automatic test_hit_single();
    x_bola = 10'd200; y_bola = 10'd100; raio_bola = 10'd5;
    fila.push_back('{ativos: 4'b1101, pontos: 16'd1});
    aplicar_reset();
    esperar_acerto("hit_single", 1);
    n_cmp++;
    if (raio_inimigos[19:10] !== 10'd0 || raio_inimigos[9:0] !== 10'd5) begin
      n_err++; $display("FAIL hit_raio: raio1=%0d raio0=%0d required 0 5", raio_inimigos[19:10], raio_inimigos[9:0]);
    end
    bola_longe();
    @(negedge clk);
    n_cmp++;
    if (acerto !== 1'b0 || pontos !== 16'd1) begin
      n_err++; $display("FAIL hit_pulse_len: acerto=%b pontos=%0d required 0 1", acerto, pontos);
    end
  endtask

  task automatic test_back_to_back();
    x_bola = 10'd140; y_bola = 10'd100; raio_bola = 10'd60;
    fila.push_back('{ativos: 4'b1110, pontos: 16'd1});
    fila.push_back('{ativos: 4'b1100, pontos: 16'd2});
    aplicar_reset();
    esperar_acerto("b2b_first", 1);
    esperar_acerto("b2b_second", 1);
    @(negedge clk);
    n_cmp++;
    if (acerto !== 1'b0 || ativos !== 4'b1100 || pontos !== 16'd2) begin
      n_err++; $display("FAIL b2b_after: acerto=%b ativos=%b pontos=%0d required 0 1100 2", acerto, ativos, pontos);
    end
    bola_longe();
  endtask

  task automatic test_pausa();
    int viu = 0;
    pausa = 1'b1;
    x_bola = 10'd80; y_bola = 10'd100; raio_bola = 10'd5;
    x_nave = 10'd315; y_nave = 10'd95; largura_nave = 10'd10; altura_nave = 10'd10;
    aplicar_reset();
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (acerto || nave_atingida) viu = 1;
    end
    n_cmp++;
    if (viu != 0 || x_inimigos !== {10'd440, 10'd320, 10'd200, 10'd80} || ativos !== 4'b1111) begin
      n_err++; $display("FAIL pausa_hold: events=%0d x=%h ativos=%b required 0 %h 1111",
                        viu, x_inimigos, ativos, {10'd440, 10'd320, 10'd200, 10'd80});
    end
    fila.push_back('{ativos: 4'b1110, pontos: 16'd1});
    pausa = 1'b0;
    esperar_acerto("pausa_release_hit", 1);
    n_cmp++;
    if (nave_atingida !== 1'b1) begin
      n_err++; $display("FAIL nave_set: got %b required 1", nave_atingida);
    end
    nave_longe(); bola_longe();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (nave_atingida !== 1'b1) begin
      n_err++; $display("FAIL nave_sticky: got %b required 1", nave_atingida);
    end
    // restart while the ball sits on enemy 1: its acerto must be swallowed
    x_bola = 10'd200; raio_bola = 10'd5;
    reiniciarJogo = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (acerto !== 1'b0 || pontos !== 16'd0 || nave_atingida !== 1'b0 || ativos !== 4'b1111) begin
      n_err++; $display("FAIL restart: acerto=%b pontos=%0d nave=%b ativos=%b required 0 0 0 1111",
                        acerto, pontos, nave_atingida, ativos);
    end
    reiniciarJogo = 1'b0;
    bola_longe();
    @(negedge clk);
  endtask

  task automatic test_fim_onda();
    x_bola = 10'd260; y_bola = 10'd100; raio_bola = 10'd200;
    fila.push_back('{ativos: 4'b1110, pontos: 16'd1});
    fila.push_back('{ativos: 4'b1100, pontos: 16'd2});
    fila.push_back('{ativos: 4'b1000, pontos: 16'd3});
    fila.push_back('{ativos: 4'b0000, pontos: 16'd4});
    aplicar_reset();
    esperar_acerto("onda_0", 1);
    esperar_acerto("onda_1", 1);
    esperar_acerto("onda_2", 1);
    esperar_acerto("onda_3", 1);
    bola_longe();
    n_cmp++;
    if (fim_onda !== 1'b1 || raio_inimigos !== 40'd0) begin
      n_err++; $display("FAIL fim_onda: got %b raio=%h required 1 0", fim_onda, raio_inimigos);
    end
`ifndef INIMIGO_RESPAWN_EN
    repeat (40) @(negedge clk);
    n_cmp++;
    if (ativos !== 4'b0000 || fim_onda !== 1'b1 || pontos !== 16'd4) begin
      n_err++; $display("FAIL terminal: ativos=%b fim=%b pontos=%0d required 0000 1 4", ativos, fim_onda, pontos);
    end
`endif
  endtask

`ifdef INIMIGO_RESPAWN_EN
  task automatic test_respawn();
    x_bola = 10'd80; y_bola = 10'd100; raio_bola = 10'd5;
    fila.push_back('{ativos: 4'b1110, pontos: 16'd1});
    aplicar_reset();
    esperar_acerto("respawn_hit", 1);
    bola_longe();
    repeat (10) @(negedge clk);
    n_cmp++;
    if (ativos[0] !== 1'b0) begin
      n_err++; $display("FAIL respawn_early: ativo0=%b required 0", ativos[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (ativos[0] !== 1'b1 || x_inimigos[9:0] !== 10'd80 || y_inimigos[9:0] !== 10'd100) begin
      n_err++; $display("FAIL respawn: ativo0=%b x0=%0d y0=%0d required 1 80 100",
                        ativos[0], x_inimigos[9:0], y_inimigos[9:0]);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pausa = 1'b0; reiniciarJogo = 1'b0;
    bola_longe(); nave_longe();
    @(negedge clk);
    test_reset();
    test_motion();
    test_hit_single();
    test_back_to_back();
    test_pausa();
    test_fim_onda();
`ifdef INIMIGO_RESPAWN_EN
    test_respawn();
`endif
    n_cmp++;
    if (fila.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d entries left, required 0", fila.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
